// File: rtl/timer_pkg.sv
// Shared types and constants for the timer/stopwatch run control.
// Time fields are plain binary: minutes, seconds, hundredths.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    localparam int MIN_W   = 7;
    localparam int SEC_W   = 6;
    localparam int CENTI_W = 7;
    localparam int DIV_W   = 20;

    localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(59);
    localparam logic [CENTI_W-1:0] CENTI_LAST = CENTI_W'(99);

endpackage

// File: rtl/tick_sync.sv
// Brings the divider square wave into the i_clk domain and turns
// each rising edge into a single-cycle pulse.
module tick_sync (
    input  logic i_clk,
    input  logic i_reset_l,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge i_clk or negedge i_reset_l) begin
        if (!i_reset_l) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/timer_control.sv
// Timer/stopwatch run control: gates the clock divider and keeps
// a MM:SS.CC value counting up (stopwatch) or down (timer).
module timer_control
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int MAX_MIN = 99
) (
    input  logic               i_clk,
    input  logic               i_reset_l,
    input  logic               i_start_stop,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [MIN_W-1:0]   i_load_min,
    input  logic [SEC_W-1:0]   i_load_sec,
    input  logic               i_mode,
    input  logic               i_div_clk,
    output logic [DIV_W-1:0]   o_div_max_count,
    output logic               o_div_reset_l,
    output logic [MIN_W-1:0]   o_min,
    output logic [SEC_W-1:0]   o_sec,
    output logic [CENTI_W-1:0] o_centi,
    output logic               o_running,
    output logic               o_done
);

    localparam int DIV_MAX = CLK_HZ / (2 * TICK_HZ) - 1;
    localparam logic [DIV_W-1:0] DIV_MAX_V = DIV_W'(DIV_MAX);
    localparam logic [MIN_W-1:0] MIN_LAST  = MIN_W'(MAX_MIN);

    state_t               r_state;
    logic                 r_mode;
    logic [MIN_W-1:0]     r_min;
    logic [SEC_W-1:0]     r_sec;
    logic [CENTI_W-1:0]   r_centi;

    logic                 w_tick;
    logic                 w_zero;
    logic                 w_start_ok;
    logic [MIN_W-1:0]     w_load_min;
    logic [SEC_W-1:0]     w_load_sec;

    logic [MIN_W-1:0]     w_up_min;
    logic [SEC_W-1:0]     w_up_sec;
    logic [CENTI_W-1:0]   w_up_centi;
    logic                 w_up_hit;

    logic [MIN_W-1:0]     w_dn_min;
    logic [SEC_W-1:0]     w_dn_sec;
    logic [CENTI_W-1:0]   w_dn_centi;
    logic                 w_dn_hit;

    logic [MIN_W-1:0]     w_nx_min;
    logic [SEC_W-1:0]     w_nx_sec;
    logic [CENTI_W-1:0]   w_nx_centi;
    logic                 w_nx_hit;

    tick_sync u_tick_sync (
        .i_clk     (i_clk),
        .i_reset_l (i_reset_l),
        .i_async   (i_div_clk),
        .o_pulse   (w_tick)
    );

    assign w_zero = (r_min == '0) && (r_sec == '0) && (r_centi == '0);

    // A timer with nothing left on it has nothing to count
    assign w_start_ok = !((i_mode == MODE_DOWN) && w_zero);

    assign w_load_min = (i_load_min > MIN_LAST) ? MIN_LAST : i_load_min;
    assign w_load_sec = (i_load_sec > SEC_LAST) ? SEC_LAST : i_load_sec;

    // Count-up step with carries from hundredths into seconds into minutes
    always_comb begin
        w_up_min   = r_min;
        w_up_sec   = r_sec;
        w_up_centi = r_centi + CENTI_W'(1);
        if (r_centi == CENTI_LAST) begin
            w_up_centi = '0;
            if (r_sec == SEC_LAST) begin
                w_up_sec = '0;
                w_up_min = r_min + MIN_W'(1);
            end else begin
                w_up_sec = r_sec + SEC_W'(1);
            end
        end
        w_up_hit = (w_up_min == MIN_LAST) &&
                   (w_up_sec == SEC_LAST) &&
                   (w_up_centi == CENTI_LAST);
    end

    // Count-down step with borrows from seconds and minutes
    always_comb begin
        w_dn_min   = r_min;
        w_dn_sec   = r_sec;
        w_dn_centi = r_centi - CENTI_W'(1);
        if (r_centi == '0) begin
            w_dn_centi = CENTI_LAST;
            if (r_sec == '0) begin
                w_dn_sec = SEC_LAST;
                w_dn_min = r_min - MIN_W'(1);
            end else begin
                w_dn_sec = r_sec - SEC_W'(1);
            end
        end
        w_dn_hit = (w_dn_min == '0) &&
                   (w_dn_sec == '0) &&
                   (w_dn_centi == '0);
    end

    // Pick the step matching the mode latched at start
    always_comb begin
        w_nx_min   = w_up_min;
        w_nx_sec   = w_up_sec;
        w_nx_centi = w_up_centi;
        w_nx_hit   = w_up_hit;
        if (r_mode == MODE_DOWN) begin
            w_nx_min   = w_dn_min;
            w_nx_sec   = w_dn_sec;
            w_nx_centi = w_dn_centi;
            w_nx_hit   = w_dn_hit;
        end
    end

    // Run-control FSM and time registers; clear beats start beats tick
    always_ff @(posedge i_clk or negedge i_reset_l) begin
        if (!i_reset_l) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_UP;
            r_min   <= '0;
            r_sec   <= '0;
            r_centi <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_clear) begin
                        r_min   <= '0;
                        r_sec   <= '0;
                        r_centi <= '0;
                    end else if (i_load) begin
                        r_min   <= w_load_min;
                        r_sec   <= w_load_sec;
                        r_centi <= '0;
                    end else if (i_start_stop && w_start_ok) begin
                        r_state <= ST_RUN;
                        r_mode  <= i_mode;
                    end
                end
                ST_RUN: begin
                    if (i_clear) begin
                        r_state <= ST_IDLE;
                        r_min   <= '0;
                        r_sec   <= '0;
                        r_centi <= '0;
                    end else if (i_start_stop) begin
                        r_state <= ST_PAUSE;
                    end else if (w_tick) begin
                        r_min   <= w_nx_min;
                        r_sec   <= w_nx_sec;
                        r_centi <= w_nx_centi;
                        if (w_nx_hit) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_clear) begin
                        r_state <= ST_IDLE;
                        r_min   <= '0;
                        r_sec   <= '0;
                        r_centi <= '0;
                    end else if (i_start_stop) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (i_clear || i_start_stop) begin
                        r_state <= ST_IDLE;
                        r_min   <= '0;
                        r_sec   <= '0;
                        r_centi <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_div_max_count = DIV_MAX_V;
    assign o_running       = (r_state == ST_RUN);
    assign o_done          = (r_state == ST_DONE);
    assign o_div_reset_l   = (r_state == ST_RUN);
    assign o_min           = r_min;
    assign o_sec           = r_sec;
    assign o_centi         = r_centi;

endmodule

// File: tb/tb_timer_control.sv
// Bench for timer_control with a divider model in the loop.
// Reference model keeps time as total hundredths; scoreboard checks each output change.
module tb_timer_control;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int MAX_MIN = 99;
    localparam int DIVM    = CLK_HZ / (2 * TICK_HZ) - 1;
    localparam int PER     = 2 * (DIVM + 1);
    localparam int FIRST   = PER + 3;
    localparam int TMAX    = MAX_MIN * 6000 + 59 * 100 + 99;

    typedef struct packed {
        logic [6:0] mn;
        logic [5:0] sc;
        logic [6:0] cc;
        logic       run;
        logic       dn;
        logic       drl;
    } obs_t;

    typedef struct {
        obs_t o;
        int   cyc;
    } exp_t;

    localparam obs_t RST_OBS = '0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic        mode = 1'b0;
    logic [6:0]  load_min = '0;
    logic [5:0]  load_sec = '0;
    logic        div_clk = 1'b1;
    logic [19:0] dcnt = '0;
    logic [19:0] div_max;
    logic        div_rst_l;
    logic [6:0]  o_min;
    logic [5:0]  o_sec;
    logic [6:0]  o_centi;
    logic        running;
    logic        done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    timer_control #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .MAX_MIN (MAX_MIN)
    ) dut (
        .i_clk           (clk),
        .i_reset_l       (rst_n),
        .i_start_stop    (start_stop),
        .i_clear         (clear),
        .i_load          (load),
        .i_load_min      (load_min),
        .i_load_sec      (load_sec),
        .i_mode          (mode),
        .i_div_clk       (div_clk),
        .o_div_max_count (div_max),
        .o_div_reset_l   (div_rst_l),
        .o_min           (o_min),
        .o_sec           (o_sec),
        .o_centi         (o_centi),
        .o_running       (running),
        .o_done          (done)
    );

    // Clock divider model: square wave, held high while in reset
    always @(posedge clk or negedge div_rst_l) begin
        if (!div_rst_l) begin
            dcnt    <= '0;
            div_clk <= 1'b1;
        end else if (dcnt == div_max) begin
            dcnt    <= '0;
            div_clk <= ~div_clk;
        end else begin
            dcnt <= dcnt + 20'd1;
        end
    end

    function automatic obs_t mk(input int t, input int st);
        obs_t r;
        r.mn  = 7'(t / 6000);
        r.sc  = 6'((t % 6000) / 100);
        r.cc  = 7'(t % 100);
        r.run = (st == 1);
        r.dn  = (st == 3);
        r.drl = (st == 1);
        return r;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: 0 idle, 1 run, 2 pause, 3 done; time in hundredths
    initial begin
        int   st;
        int   t;
        int   md;
        int   rc;
        int   lm;
        int   ls;
        bit   tick;
        obs_t last;
        obs_t nx;
        st = 0; t = 0; md = 0; rc = 0; last = RST_OBS;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                st = 0; t = 0; md = 0; rc = 0;
                q.delete();
                last = RST_OBS;
            end else begin
                cyc++;
                tick = 1'b0;
                if (st == 1) begin
                    rc++;
                    tick = (rc >= FIRST) && (((rc - FIRST) % PER) == 0);
                end
                case (st)
                    0: begin
                        if (clear) t = 0;
                        else if (load) begin
                            lm = (int'(load_min) > MAX_MIN) ? MAX_MIN : int'(load_min);
                            ls = (int'(load_sec) > 59) ? 59 : int'(load_sec);
                            t = lm * 6000 + ls * 100;
                        end else if (start_stop && !(mode && t == 0)) begin
                            st = 1; md = int'(mode); rc = 0;
                        end
                    end
                    1: begin
                        if (clear) begin st = 0; t = 0; end
                        else if (start_stop) st = 2;
                        else if (tick) begin
                            if (md == 1) begin
                                t--;
                                if (t == 0) st = 3;
                            end else begin
                                t++;
                                if (t == TMAX) st = 3;
                            end
                        end
                    end
                    2: begin
                        if (clear) begin st = 0; t = 0; end
                        else if (start_stop) begin st = 1; rc = 0; end
                    end
                    default: begin
                        if (clear || start_stop) begin st = 0; t = 0; end
                    end
                endcase
                nx = mk(t, st);
                if (nx != last) q.push_back('{o: nx, cyc: cyc});
                last = nx;
            end
        end
    end

    // Monitor: every change of the DUT outputs pops one expectation
    initial begin
        obs_t last;
        obs_t cur;
        exp_t e;
        last = RST_OBS;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last = RST_OBS;
            end else begin
                cur.mn = o_min; cur.sc = o_sec; cur.cc = o_centi;
                cur.run = running; cur.dn = done; cur.drl = div_rst_l;
                checks++;
                if (running && done) begin
                    failures++;
                    $display("FAIL excl: running and done both 1 at cycle %0d", cyc);
                end
                if (cur != last) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL unexp_change: got %0d:%0d.%0d r%0d d%0d at cycle %0d, required no change",
                                 cur.mn, cur.sc, cur.cc, cur.run, cur.dn, cyc);
                    end else begin
                        e = q.pop_front();
                        if (e.o != cur || e.cyc != cyc) begin
                            failures++;
                            $display("FAIL seq: got %0d:%0d.%0d r%0d d%0d drl%0d cyc%0d required %0d:%0d.%0d r%0d d%0d drl%0d cyc%0d",
                                     cur.mn, cur.sc, cur.cc, cur.run, cur.dn, cur.drl, cyc,
                                     e.o.mn, e.o.sc, e.o.cc, e.o.run, e.o.dn, e.o.drl, e.cyc);
                        end
                    end
                    last = cur;
                end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                    checks++;
                    failures++;
                    e = q.pop_front();
                    $display("FAIL missing_change: got %0d:%0d.%0d required %0d:%0d.%0d at cycle %0d",
                             cur.mn, cur.sc, cur.cc, e.o.mn, e.o.sc, e.o.cc, e.cyc);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic p_start();
        start_stop = 1'b1; @(posedge clk); @(negedge clk); start_stop = 1'b0;
    endtask

    task automatic p_clear();
        clear = 1'b1; @(posedge clk); @(negedge clk); clear = 1'b0;
    endtask

    task automatic p_load(input int m, input int s);
        load_min = 7'(m); load_sec = 6'(s);
        load = 1'b1; @(posedge clk); @(negedge clk); load = 1'b0;
    endtask

    initial begin
        int op;
        idle(3);
        check("rst_min", o_min, 0);
        check("rst_sec", o_sec, 0);
        check("rst_centi", o_centi, 0);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_div_rst_l", div_rst_l, 0);
        check("div_max", div_max, DIVM);
        rst_n = 1'b1;
        idle(6);

        // Timer 00:01 down to zero
        mode = 1'b1;
        p_load(0, 1);
        check("t1_load_sec", o_sec, 1);
        p_start();
        idle(FIRST);
        check("t1_first_centi", o_centi, 99);
        check("t1_first_sec", o_sec, 0);
        idle(PER * 99);
        check("t1_done", done, 1);
        check("t1_time", o_min * 6000 + o_sec * 100 + o_centi, 0);
        check("t1_div_rst_l", div_rst_l, 0);
        p_clear();
        idle(6);

        // Stopwatch with pause and resume
        mode = 1'b0;
        p_start();
        idle(FIRST + PER * 149 + 1);
        p_start();
        check("t2_sec", o_sec, 1);
        check("t2_centi", o_centi, 50);
        idle(PER * 50 + 6);
        check("t2_hold", o_sec * 100 + o_centi, 150);
        check("t2_paused", running, 0);
        p_start();
        idle(FIRST + PER * 49 + 1);
        p_start();
        check("t2_resume", o_sec * 100 + o_centi, 200);
        p_clear();
        idle(6);

        // Stopwatch saturates at 99:59.99
        mode = 1'b0;
        p_load(99, 59);
        p_start();
        idle(FIRST + PER * 98);
        check("t3_min", o_min, 99);
        check("t3_sec", o_sec, 59);
        check("t3_centi", o_centi, 99);
        check("t3_done", done, 1);
        idle(PER * 10);
        check("t3_hold", o_centi, 99);
        p_clear();
        check("t3_clear", o_min, 0);
        idle(6);

        // Timer at zero ignores start; oversize load clamps
        mode = 1'b1;
        p_start();
        idle(20);
        check("t4_idle", running, 0);
        p_load(127, 63);
        check("t4_min", o_min, 99);
        check("t4_sec", o_sec, 59);
        check("t4_centi", o_centi, 0);
        p_clear();
        idle(6);

        // Clear and pause landing on a tick edge
        mode = 1'b0;
        p_start();
        idle(FIRST - 1);
        p_clear();
        check("t5_clear_centi", o_centi, 0);
        check("t5_clear_run", running, 0);
        idle(6);
        p_start();
        idle(FIRST - 1);
        p_start();
        check("t5_pause_centi", o_centi, 0);
        check("t5_pause_run", running, 0);
        p_clear();
        idle(6);
        p_start();
        idle(FIRST + PER * 4 - 1);
        p_clear();
        check("t5_clear_late", o_centi, 0);
        idle(6);

        // Asynchronous reset mid-RUN
        mode = 1'b0;
        p_start();
        idle(300);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_centi", o_centi, 0);
        check("t6_sec", o_sec, 0);
        check("t6_running", running, 0);
        check("t6_div_rst_l", div_rst_l, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: p_load($urandom_range(0, 127), $urandom_range(0, 63));
                1: p_load(0, $urandom_range(0, 2));
                2: p_clear();
                3: mode = ~mode;
                default: p_start();
            endcase
            idle($urandom_range(6, 400));
        end
        idle(20);
        check("queue_drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
